alu_issue_ctrl: RTL and testbench

//   Sequencing end of the ALU decoder interface. Accepts one decoded instruction per handshake and drives

---
 rtl/alu_issue_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Issue/sequencing controller in front of the ALU decoder.
//                Accepts one decoded instruction per handshake, holds the
//                opcode stable while the datapath settles, then captures the
//                returned C/V/Z flags and strobes the register-file write.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       InstrValid,
    output logic       InstrReady,
    input  logic [4:0] InstrOp,
    input  logic [3:0] InstrImm4,
    input  logic       Abort,
    output logic [4:0] OpCode,
    output logic [3:0] imm4,
    output logic       Cin,
    input  logic       C,
    input  logic       V,
    input  logic       Z,
    output logic       CFlag,
    output logic       VFlag,
    output logic       ZFlag,
    output logic       RegWe,
    output logic       Busy
);

    localparam logic [4:0] C_OP_NOP  = 5'b11000;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC    = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       opcode_q, opcode_d;
    logic [3:0]       imm4_q, imm4_d;
    logic             cflag_q, cflag_d;
    logic             vflag_q, vflag_d;
    logic             zflag_q, zflag_d;
    logic             regwe_q, regwe_d;

    logic             w_accept;
    logic             w_sample;
    logic             w_upd_cvz;
    logic             w_upd_z;
    logic             w_wb;

    // Handshake only in IDLE; an Abort in the same cycle blocks acceptance.
    assign w_accept = (state_q == S_IDLE) & InstrValid & ~Abort;
    // Flags are captured on the last EXEC edge unless that edge is aborted.
    assign w_sample = (state_q == S_EXEC) & (cnt_q == '0) & ~Abort;

    // Decode the in-flight opcode into flag-update class and writeback.
    always_comb begin
        w_upd_cvz = 1'b0;
        w_upd_z   = 1'b0;
        w_wb      = 1'b1;
        case (opcode_q)
            5'b00000, 5'b00001, 5'b01000, 5'b01001: w_upd_cvz = 1'b0;
            default:                                w_upd_cvz = ~opcode_q[4];
        endcase
        case (opcode_q)
            5'b10100, 5'b10101:                     w_upd_z = 1'b0;
            5'b11010, 5'b11100, 5'b11101, 5'b11111: w_upd_z = 1'b1;
            default:                                w_upd_z = (opcode_q[4:3] == 2'b10);
        endcase
        case (opcode_q)
            5'b01000, 5'b01001, 5'b00111, 5'b01111,
            5'b11000, 5'b11001, 5'b11110:           w_wb = 1'b0;
            default:                                w_wb = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EXEC -> WRITE -> IDLE, Abort returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and activity outputs decoded from the current state.
    always_comb begin
        InstrReady = (state_q == S_IDLE);
        Busy       = (state_q == S_EXEC) | (state_q == S_WRITE);
    end

    // Datapath next values: instruction latch, settle counter, flags, strobe.
    always_comb begin
        opcode_d = opcode_q;
        imm4_d   = imm4_q;
        cnt_d    = cnt_q;
        cflag_d  = cflag_q;
        vflag_d  = vflag_q;
        zflag_d  = zflag_q;
        regwe_d  = 1'b0;
        if (w_accept) begin
            opcode_d = InstrOp;
            imm4_d   = InstrImm4;
            cnt_d    = C_CNT_LOAD;
        end else if (state_q == S_EXEC) begin
            if (Abort) begin
                opcode_d = C_OP_NOP;
            end else if (w_sample) begin
                if (w_upd_cvz) begin
                    cflag_d = C;
                    vflag_d = V;
                    zflag_d = Z;
                end else if (w_upd_z) begin
                    zflag_d = Z;
                end
                regwe_d  = w_wb;
                opcode_d = C_OP_NOP;
            end else begin
                // Counter is non-zero here, so the decrement cannot wrap.
                cnt_d = cnt_q - 1'b1;
            end
        end else if (state_q == S_WRITE) begin
            opcode_d = C_OP_NOP;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            opcode_q <= C_OP_NOP;
            imm4_q   <= 4'd0;
            cnt_q    <= '0;
            cflag_q  <= 1'b0;
            vflag_q  <= 1'b0;
            zflag_q  <= 1'b0;
            regwe_q  <= 1'b0;
        end else begin
            opcode_q <= opcode_d;
            imm4_q   <= imm4_d;
            cnt_q    <= cnt_d;
            cflag_q  <= cflag_d;
            vflag_q  <= vflag_d;
            zflag_q  <= zflag_d;
            regwe_q  <= regwe_d;
        end
    end

    assign OpCode = opcode_q;
    assign imm4   = imm4_q;
    assign Cin    = cflag_q;
    assign CFlag  = cflag_q;
    assign VFlag  = vflag_q;
    assign ZFlag  = zflag_q;
    assign RegWe  = regwe_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Self-checking bench for alu_issue_ctrl. Two instances
//                (settle 1 and settle 3) share all inputs; each is tracked by
//                a behavioural model based on cycles-since-issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam logic [4:0] NOP = 5'b11000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       InstrValid = 1'b0;
    logic       Abort = 1'b0;
    logic [4:0] InstrOp = 5'd0;
    logic [3:0] InstrImm4 = 4'd0;
    logic       C = 1'b0, V = 1'b0, Z = 1'b0;

    logic       rdy1, cin1, cf1, vf1, zf1, we1, bz1;
    logic [4:0] op1;
    logic [3:0] im1;
    logic       rdy3, cin3, cf3, vf3, zf3, we3, bz3;
    logic [4:0] op3;
    logic [3:0] im3;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) u_s1 (
        .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(rdy1),
        .InstrOp(InstrOp), .InstrImm4(InstrImm4), .Abort(Abort),
        .OpCode(op1), .imm4(im1), .Cin(cin1), .C(C), .V(V), .Z(Z),
        .CFlag(cf1), .VFlag(vf1), .ZFlag(zf1), .RegWe(we1), .Busy(bz1)
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(4)) u_s3 (
        .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(rdy3),
        .InstrOp(InstrOp), .InstrImm4(InstrImm4), .Abort(Abort),
        .OpCode(op3), .imm4(im3), .Cin(cin3), .C(C), .V(V), .Z(Z),
        .CFlag(cf3), .VFlag(vf3), .ZFlag(zf3), .RegWe(we3), .Busy(bz3)
    );

    // ---------------- behavioural model ----------------
    int         S [2] = '{1, 3};
    bit         m_busy [2];
    int         m_age  [2];
    logic [4:0] m_op   [2];
    logic [3:0] m_imm  [2];
    logic       m_c [2], m_v [2], m_z [2], m_we [2];

    function automatic bit upd_all(input logic [4:0] op);
        return (op < 5'd16) && !(op inside {5'd0, 5'd1, 5'd8, 5'd9});
    endfunction

    function automatic bit upd_z_only(input logic [4:0] op);
        return ((op >= 5'd16) && (op < 5'd24) && !(op inside {5'd20, 5'd21}))
               || (op inside {5'd26, 5'd28, 5'd29, 5'd31});
    endfunction

    function automatic bit writes_back(input logic [4:0] op);
        return !(op inside {5'd7, 5'd8, 5'd9, 5'd15, 5'd24, 5'd25, 5'd30});
    endfunction

    // An issued op is sampled S edges after its handshake, strobes for one cycle, then retires.
    always @(posedge Clock or posedge Reset) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_busy[i] = 1'b0; m_age[i] = 0; m_op[i] = NOP; m_imm[i] = 4'd0;
                m_c[i] = 1'b0; m_v[i] = 1'b0; m_z[i] = 1'b0; m_we[i] = 1'b0;
            end else if (m_busy[i]) begin
                m_age[i] = m_age[i] + 1;
                if (Abort) begin
                    m_busy[i] = 1'b0; m_op[i] = NOP; m_we[i] = 1'b0;
                end else if (m_age[i] == S[i]) begin
                    if (upd_all(m_op[i])) begin
                        m_c[i] = C; m_v[i] = V; m_z[i] = Z;
                    end else if (upd_z_only(m_op[i])) begin
                        m_z[i] = Z;
                    end
                    m_we[i] = writes_back(m_op[i]);
                    m_op[i] = NOP;
                end else if (m_age[i] == S[i] + 1) begin
                    m_busy[i] = 1'b0; m_we[i] = 1'b0;
                end
            end else if (InstrValid && !Abort) begin
                m_busy[i] = 1'b1; m_age[i] = 0; m_op[i] = InstrOp; m_imm[i] = InstrImm4;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input int i, input logic rdy, input logic [4:0] op,
                            input logic [3:0] im, input logic cin, input logic cf,
                            input logic vf, input logic zf, input logic we, input logic bz);
        string p;
        p = $sformatf("s%0d_", S[i]);
        chk({p, "InstrReady"}, 8'(rdy), 8'(!m_busy[i]));
        chk({p, "Busy"},       8'(bz),  8'(m_busy[i]));
        chk({p, "OpCode"},     8'(op),  8'(m_op[i]));
        chk({p, "imm4"},       8'(im),  8'(m_imm[i]));
        chk({p, "Cin"},        8'(cin), 8'(m_c[i]));
        chk({p, "CFlag"},      8'(cf),  8'(m_c[i]));
        chk({p, "VFlag"},      8'(vf),  8'(m_v[i]));
        chk({p, "ZFlag"},      8'(zf),  8'(m_z[i]));
        chk({p, "RegWe"},      8'(we),  8'(m_we[i]));
    endtask

    // Every cycle, away from the rising edge, compare both instances to the model.
    always @(negedge Clock) begin
        chk_inst(0, rdy1, op1, im1, cin1, cf1, vf1, zf1, we1, bz1);
        chk_inst(1, rdy3, op3, im3, cin3, cf3, vf3, zf3, we3, bz3);
    end

    // Called at edge+1; presents the instruction for one edge, returns at edge+1 after it.
    task automatic issue(input logic [4:0] op, input logic [3:0] imm);
        InstrValid = 1'b1; InstrOp = op; InstrImm4 = imm;
        @(posedge Clock); #1;
        InstrValid = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clock); #1;
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        chk("rst_opcode", 8'(op1), 8'(NOP));
        chk("rst_ready",  8'(rdy1), 8'd1);
        chk("rst_regwe",  8'(we1), 8'd0);
        chk("rst_flags",  8'({cf1, vf1, zf1}), 8'd0);

        // ADD with C=1 V=0 Z=1
        C = 1'b1; V = 1'b0; Z = 1'b1;
        issue(5'b00010, 4'd0);
        chk("add_exec_op", 8'(op1), 8'(5'b00010));
        chk("add_exec_ready", 8'(rdy1), 8'd0);
        chk("add_exec_we", 8'(we1), 8'd0);
        tick();
        chk("add_write_we", 8'(we1), 8'd1);
        chk("add_write_flags", 8'({cf1, vf1, zf1}), 8'(3'b101));
        chk("add_write_ready", 8'(rdy1), 8'd0);
        chk("add_write_op", 8'(op1), 8'(NOP));
        tick();
        chk("add_idle_ready", 8'(rdy1), 8'd1);
        chk("add_idle_we", 8'(we1), 8'd0);

        // CMP: flags update, no writeback
        C = 1'b0; V = 1'b1; Z = 1'b0;
        issue(5'b00111, 4'd0);
        tick();
        chk("cmp_flags", 8'({cf1, vf1, zf1}), 8'(3'b010));
        chk("cmp_we", 8'(we1), 8'd0);
        tick();
        chk("cmp_we_after", 8'(we1), 8'd0);

        // Set carry, then ADC sees Cin=1, then AND keeps C
        C = 1'b1; V = 1'b0; Z = 1'b0;
        issue(5'b00010, 4'd0);
        tick(); tick();
        chk("adc_pre_cin", 8'(cin1), 8'd1);
        issue(5'b00100, 4'd0);
        chk("adc_exec_cin", 8'(cin1), 8'd1);
        tick();
        chk("adc_write_cf", 8'(cf1), 8'd1);
        tick();
        C = 1'b0; V = 1'b1; Z = 1'b1;
        issue(5'b10000, 4'd0);
        tick();
        chk("and_flags", 8'({cf1, vf1, zf1}), 8'(3'b101));
        chk("and_we", 8'(we1), 8'd1);
        tick();

        // SUB aborted on its sample edge
        C = 1'b0; V = 1'b1; Z = 1'b0;
        issue(5'b01010, 4'd0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("abort_we", 8'(we1), 8'd0);
        chk("abort_flags", 8'({cf1, vf1, zf1}), 8'(3'b101));
        chk("abort_ready", 8'(rdy1), 8'd1);
        chk("abort_op", 8'(op1), 8'(NOP));
        tick();
        chk("abort_we_next", 8'(we1), 8'd0);

        // Abort in IDLE blocks a simultaneous handshake
        Abort = 1'b1;
        issue(5'b00010, 4'd3);
        Abort = 1'b0;
        chk("idle_abort_ready", 8'(rdy1), 8'd1);
        chk("idle_abort_busy", 8'(bz1), 8'd0);
        chk("idle_abort_op", 8'(op1), 8'(NOP));

        // Reset in the middle of EXEC
        C = 1'b1; V = 1'b1; Z = 1'b1;
        issue(5'b00010, 4'd5);
        #1 Reset = 1'b1;
        #1;
        chk("midrst_op", 8'(op1), 8'(NOP));
        chk("midrst_we", 8'(we1), 8'd0);
        chk("midrst_flags", 8'({cf1, vf1, zf1}), 8'd0);
        chk("midrst_ready", 8'(rdy1), 8'd1);
        @(posedge Clock); #1 Reset = 1'b0;

        // LSL held for three EXEC cycles on the settle-3 instance
        C = 1'b1; V = 1'b1; Z = 1'b0;
        issue(5'b11111, 4'd9);
        for (int k = 0; k < 3; k++) begin
            chk("lsl_exec_op", 8'(op3), 8'(5'b11111));
            chk("lsl_exec_imm", 8'(im3), 8'(4'b1001));
            chk("lsl_exec_we", 8'(we3), 8'd0);
            tick();
        end
        chk("lsl_write_we", 8'(we3), 8'd1);
        chk("lsl_write_op", 8'(op3), 8'(NOP));
        chk("lsl_write_cv", 8'({cf3, vf3}), 8'd0);
        tick();
        chk("lsl_after_we", 8'(we3), 8'd0);
        chk("lsl_after_ready", 8'(rdy3), 8'd1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            InstrValid = ($urandom_range(0, 99) < 60);
            InstrOp    = 5'($urandom);
            InstrImm4  = 4'($urandom);
            Abort      = ($urandom_range(0, 15) == 0);
            C          = 1'($urandom);
            V          = 1'($urandom);
            Z          = 1'($urandom);
            Reset      = ($urandom_range(0, 399) == 0);
            tick();
        end
        InstrValid = 1'b0; Abort = 1'b0; Reset = 1'b0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
